// File: rtl/wave_sample_scheduler.sv
// Two programmable sample-rate dividers (channels A/B) feeding a round-robin
// arbiter that shares one DAC/LUT write port through a req/ack handshake.
module wave_sample_scheduler #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DEF_DIV = 50
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_a,
  input  logic [DIV_W-1:0] div_b,
  input  logic             cfg_load,
  input  logic             dac_ack,
  input  logic             ovr_clr,
  output logic             tick_a,
  output logic             tick_b,
  output logic             dac_req,
  output logic             dac_ch,
  output logic             ovr_a,
  output logic             ovr_b
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic             last;
  logic [DIV_W-1:0] shadow_a;
  logic [DIV_W-1:0] shadow_b;
  logic [DIV_W-1:0] cnt_a;
  logic [DIV_W-1:0] cnt_b;
  logic             pend_a;
  logic             pend_b;

  logic term_a_c;
  logic term_b_c;
  logic grant_a_c;
  logic grant_b_c;

  // A terminal count is the per-channel "sample due" event; cfg_load suppresses it.
  assign term_a_c = !cfg_load && en && (cnt_a == shadow_a);
  assign term_b_c = !cfg_load && en && (cnt_b == shadow_b);

  // last=1 means B was served last, so A wins a tie.
  assign grant_a_c = (state == IDLE) && pend_a && (!pend_b || last);
  assign grant_b_c = (state == IDLE) && pend_b && (!pend_a || !last);

  // Dividers: shadow divisor, counter and tick pulse per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_a <= DIV_W'(DEF_DIV);
      shadow_b <= DIV_W'(DEF_DIV);
      cnt_a    <= '0;
      cnt_b    <= '0;
      tick_a   <= 1'b0;
      tick_b   <= 1'b0;
    end else if (cfg_load) begin
      shadow_a <= div_a;
      shadow_b <= div_b;
      cnt_a    <= '0;
      cnt_b    <= '0;
      tick_a   <= 1'b0;
      tick_b   <= 1'b0;
    end else begin
      tick_a <= term_a_c;
      tick_b <= term_b_c;
      if (en) begin
        cnt_a <= term_a_c ? '0 : cnt_a + DIV_W'(1);
        cnt_b <= term_b_c ? '0 : cnt_b + DIV_W'(1);
      end
    end
  end

  // Pending flags and sticky overrun; a new terminal outranks the grant's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      ovr_a  <= 1'b0;
      ovr_b  <= 1'b0;
    end else begin
      if (term_a_c)       pend_a <= 1'b1;
      else if (grant_a_c) pend_a <= 1'b0;
      if (term_b_c)       pend_b <= 1'b1;
      else if (grant_b_c) pend_b <= 1'b0;

      if (term_a_c && pend_a && !grant_a_c) ovr_a <= 1'b1;
      else if (ovr_clr)                      ovr_a <= 1'b0;
      if (term_b_c && pend_b && !grant_b_c) ovr_b <= 1'b1;
      else if (ovr_clr)                      ovr_b <= 1'b0;
    end
  end

  // Arbiter: IDLE issues one request, GRANT holds it until acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 1'b1;
      dac_req <= 1'b0;
      dac_ch  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a_c || grant_b_c) begin
            dac_req <= 1'b1;
            dac_ch  <= grant_b_c;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (dac_ack) begin
            dac_req <= 1'b0;
            last    <= dac_ch;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
